// File: rtl/vm_pkg.sv
// Shared types and constants for the vending transaction sequencer.
// Coin and item encodings, FSM state type and the menu price list.
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DISPENSE,
    ST_PAYOUT
  } vm_state_e;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_10   = 2'd1;
  localparam logic [1:0] COIN_20   = 2'd2;
  localparam logic [1:0] COIN_30   = 2'd3;

  localparam logic [2:0] ITEM_NONE      = 3'd0;
  localparam logic [2:0] ITEM_COFFEE    = 3'd1;
  localparam logic [2:0] ITEM_SNACKS    = 3'd2;
  localparam logic [2:0] ITEM_WATER     = 3'd3;
  localparam logic [2:0] ITEM_COOLDRINK = 3'd4;
  localparam logic [2:0] MAX_ITEM       = ITEM_COOLDRINK;

  // prices in 10 Rs units
  localparam int PRICE_COFFEE    = 2;
  localparam int PRICE_SNACKS    = 3;
  localparam int PRICE_WATER     = 1;
  localparam int PRICE_COOLDRINK = 2;

endpackage

// File: rtl/vm_price_rom.sv
// Menu price lookup: item code to price in 10 Rs units.
// Codes outside 1..MAX_ITEM report valid=0 and price 0.
module vm_price_rom
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 4
) (
  input  logic [2:0]          item,
  output logic [CREDIT_W-1:0] price,
  output logic                valid
);

  // decode item code into price and menu validity
  always_comb begin
    price = '0;
    valid = (item != ITEM_NONE) && (item <= MAX_ITEM);
    unique case (item)
      ITEM_COFFEE:    price = CREDIT_W'(PRICE_COFFEE);
      ITEM_SNACKS:    price = CREDIT_W'(PRICE_SNACKS);
      ITEM_WATER:     price = CREDIT_W'(PRICE_WATER);
      ITEM_COOLDRINK: price = CREDIT_W'(PRICE_COOLDRINK);
      default:        price = '0;
    endcase
  end

endmodule

// File: rtl/vm_vend_sequencer.sv
// Vending transaction sequencer: credit collection, item dispense
// handshake and coin-by-coin change payout with timeout/cancel refund.
module vm_vend_sequencer
  import vm_pkg::*;
#(
  parameter int CREDIT_W    = 4,
  parameter int MAX_CREDIT  = 6,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic [2:0]          choice,
  input  logic                cancel,
  output logic                disp_req,
  output logic [2:0]          disp_item,
  input  logic                disp_ack,
  output logic                chg_req,
  output logic [1:0]          chg_coin,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_rej,
  output logic                err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int SUM_W = CREDIT_W + 1;

  vm_state_e           state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                disp_req_q, disp_req_d;
  logic [2:0]          disp_item_q, disp_item_d;
  logic                chg_req_q, chg_req_d;
  logic [1:0]          chg_coin_q, chg_coin_d;
  logic                busy_q, busy_d;
  logic                coin_rej_q, coin_rej_d;
  logic                err_q, err_d;

  logic [CREDIT_W-1:0] rom_price;
  logic                rom_valid;
  logic [SUM_W-1:0]    coin_sum;
  logic                coin_in;
  logic                coin_ok;
  logic                refund;

  vm_price_rom #(
    .CREDIT_W(CREDIT_W)
  ) u_rom (
    .item (choice),
    .price(rom_price),
    .valid(rom_valid)
  );

  // largest coin that does not overpay the remaining credit
  function automatic logic [1:0] pay_coin(
    input logic [CREDIT_W-1:0] c
  );
    if (c >= CREDIT_W'(3)) return COIN_30;
    else if (c == CREDIT_W'(2)) return COIN_20;
    else return COIN_10;
  endfunction

  assign coin_in  = (coin != COIN_NONE);
  assign coin_sum = {1'b0, credit_q} + SUM_W'(coin);
  assign coin_ok  = coin_in &&
                    (coin_sum <= SUM_W'(MAX_CREDIT));

  // next-state, credit and registered-output computation
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    price_d     = price_q;
    timer_d     = timer_q;
    disp_req_d  = 1'b0;
    disp_item_d = disp_item_q;
    chg_req_d   = 1'b0;
    chg_coin_d  = chg_coin_q;
    coin_rej_d  = 1'b0;
    err_d       = 1'b0;
    refund      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (coin_ok) credit_d = coin_sum[CREDIT_W-1:0];
        else if (coin_in) coin_rej_d = 1'b1;
        if (choice != ITEM_NONE) begin
          if (rom_valid) begin
            price_d     = rom_price;
            disp_item_d = choice;
            if ({1'b0, credit_d} >= {1'b0, rom_price}) begin
              state_d    = ST_DISPENSE;
              disp_req_d = 1'b1;
            end else begin
              state_d = ST_COLLECT;
              timer_d = TMR_W'(TIMEOUT_CYC);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_COLLECT: begin
        if (cancel) begin
          coin_rej_d = coin_in;
          refund     = 1'b1;
        end else begin
          if (coin_ok) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            timer_d  = TMR_W'(TIMEOUT_CYC);
          end else if (coin_in) begin
            coin_rej_d = 1'b1;
          end
          if ({1'b0, credit_d} >= {1'b0, price_q}) begin
            state_d    = ST_DISPENSE;
            disp_req_d = 1'b1;
          end else if (!coin_ok) begin
            if (timer_q <= TMR_W'(1)) refund = 1'b1;
            else timer_d = timer_q - TMR_W'(1);
          end
        end
        if (refund) begin
          if (credit_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_PAYOUT;
            chg_req_d  = 1'b1;
            chg_coin_d = pay_coin(credit_q);
          end
        end
      end

      ST_DISPENSE: begin
        coin_rej_d = coin_in;
        if (disp_ack) begin
          credit_d = credit_q - price_q;
          if (credit_d == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_PAYOUT;
            chg_req_d  = 1'b1;
            chg_coin_d = pay_coin(credit_d);
          end
        end else begin
          disp_req_d = 1'b1;
        end
      end

      ST_PAYOUT: begin
        coin_rej_d = coin_in;
        if (chg_req_q) begin
          if (chg_ack) begin
            credit_d   = credit_q - CREDIT_W'(chg_coin_q);
            chg_coin_d = COIN_NONE;
            if (credit_d == '0) state_d = ST_IDLE;
          end else begin
            chg_req_d = 1'b1;
          end
        end else begin
          chg_req_d  = 1'b1;
          chg_coin_d = pay_coin(credit_q);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // state, credit and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      credit_q    <= '0;
      price_q     <= '0;
      timer_q     <= '0;
      disp_req_q  <= 1'b0;
      disp_item_q <= '0;
      chg_req_q   <= 1'b0;
      chg_coin_q  <= '0;
      busy_q      <= 1'b0;
      coin_rej_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      price_q     <= price_d;
      timer_q     <= timer_d;
      disp_req_q  <= disp_req_d;
      disp_item_q <= disp_item_d;
      chg_req_q   <= chg_req_d;
      chg_coin_q  <= chg_coin_d;
      busy_q      <= busy_d;
      coin_rej_q  <= coin_rej_d;
      err_q       <= err_d;
    end
  end

  assign disp_req  = disp_req_q;
  assign disp_item = disp_item_q;
  assign chg_req   = chg_req_q;
  assign chg_coin  = chg_coin_q;
  assign credit    = credit_q;
  assign busy      = busy_q;
  assign coin_rej  = coin_rej_q;
  assign err       = err_q;

endmodule
